// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 6502 memory-port bus initiators.
// Holds the transfer state encoding, default bus widths and the
// wrapping address-increment helper.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Increment an address of width w, wrapping to zero past the top.
  // Callers pass the address zero-extended to 32 bits and slice the result.
  function automatic logic [31:0] addr_inc(input logic [31:0] a, input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (a + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Block copy / fill engine on the 6502 RAM port.
// Copy: 2 cycles per byte, fill: 1 cycle per byte, plus 1 request cycle and 1 done cycle.
// Backpressure: holds BusReq until granted; losing BusGrant suppresses WE at once and re-requests.
module mem_dma
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic              Fill,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  input  logic [DATA_W-1:0] FillValue,
  input  logic              BusGrant,
  input  logic [DATA_W-1:0] MemRData,
  output logic              BusReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWData,
  output logic              Busy,
  output logic              Done
);

  state_t            r_state;
  logic              r_fill;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_fill_val;
  logic              r_busreq;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_src_next;
  logic [ADDR_W-1:0] w_dst_next;
  logic [DATA_W-1:0] w_wdata;

  assign w_src_next = ADDR_W'(addr_inc(32'(r_src), ADDR_W));
  assign w_dst_next = ADDR_W'(addr_inc(32'(r_dst), ADDR_W));

  // Copy data comes straight from the RAM read port in the WRITE cycle,
  // since the registered read only becomes valid in that cycle.
  assign w_wdata = r_fill ? r_fill_val : MemRData;

  // Outside WRITE the data bus shows the last byte written.
  assign MemWData = (r_state == WRITE) ? w_wdata : r_wdata;

  // WE is dropped in the same cycle that grant is lost or reset is asserted,
  // so no byte lands in memory while the CPU owns the bus or during an abort.
  assign MemWE      = r_we & BusGrant & RESET_N;
  assign MemAddress = r_addr;
  assign BusReq     = r_busreq;
  assign Busy       = r_busy;
  assign Done       = r_done;

  // Transfer sequencer: command latch, counters and registered bus outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_fill     <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_fill_val <= '0;
      r_busreq   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            if (Len != '0) begin
              r_fill     <= Fill;
              r_src      <= SrcAddr;
              r_dst      <= DstAddr;
              r_rem      <= Len;
              r_fill_val <= FillValue;
              r_busreq   <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= REQ;
            end else begin
              // Zero-length command completes without touching the bus.
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end

        REQ: begin
          if (BusGrant) begin
            if (r_fill) begin
              r_addr  <= r_dst;
              r_we    <= 1'b1;
              r_state <= WRITE;
            end else begin
              // A paused copy always re-reads the source: the CPU may
              // have changed RAM DataOut while it held the bus.
              r_addr  <= r_src;
              r_we    <= 1'b0;
              r_state <= READ;
            end
          end
        end

        READ: begin
          if (!BusGrant) begin
            r_state <= REQ;
          end else begin
            r_addr  <= r_dst;
            r_we    <= 1'b1;
            r_state <= WRITE;
          end
        end

        WRITE: begin
          if (!BusGrant) begin
            r_we    <= 1'b0;
            r_state <= REQ;
          end else begin
            r_wdata <= w_wdata;
            r_dst   <= w_dst_next;
            if (!r_fill) begin
              r_src <= w_src_next;
            end
            r_rem <= r_rem - ADDR_W'(1);
            if (r_rem == ADDR_W'(1)) begin
              r_we     <= 1'b0;
              r_busreq <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else if (r_fill) begin
              r_addr  <= w_dst_next;
              r_state <= WRITE;
            end else begin
              r_addr  <= w_src_next;
              r_we    <= 1'b0;
              r_state <= READ;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a 64 KiB synchronous RAM model
// whose port is shared with a bench-driven CPU path while grant is low.
module tb_mem_dma;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        Start;
  logic        Fill;
  logic [15:0] SrcAddr;
  logic [15:0] DstAddr;
  logic [15:0] Len;
  logic [7:0]  FillValue;
  logic        BusGrant;
  logic [7:0]  MemRData;
  logic        BusReq;
  logic        MemWE;
  logic [15:0] MemAddress;
  logic [7:0]  MemWData;
  logic        Busy;
  logic        Done;

  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;

  logic [7:0]  mem [0:65535];
  int          we_total   = 0;
  int          we_nogrant = 0;
  int          done_total = 0;

  int checks = 0;
  int errors = 0;

  mem_dma #(.ADDR_W(16), .DATA_W(8)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .Start      (Start),
    .Fill       (Fill),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .FillValue  (FillValue),
    .BusGrant   (BusGrant),
    .MemRData   (MemRData),
    .BusReq     (BusReq),
    .MemWE      (MemWE),
    .MemAddress (MemAddress),
    .MemWData   (MemWData),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 CLK = ~CLK;

  // RAM model: the DMA owns the port while granted, otherwise the CPU path.
  always @(posedge CLK) begin
    if (MemWE) begin
      mem[MemAddress] <= MemWData;
      we_total <= we_total + 1;
      if (!BusGrant) we_nogrant <= we_nogrant + 1;
    end else if (!BusGrant && cpu_we) begin
      mem[cpu_addr] <= cpu_dat;
    end
    MemRData <= mem[BusGrant ? MemAddress : cpu_addr];
    if (Done) done_total <= done_total + 1;
  end

  // Preload one RAM byte through the CPU path (caller sits at a negedge).
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    BusGrant = 1'b0; cpu_we = 1'b1; cpu_addr = a; cpu_dat = d;
    @(negedge CLK);
    cpu_we = 1'b0; BusGrant = 1'b1;
  endtask

  // Issue a one-cycle Start; returns at the negedge of cycle 1 (Start was cycle 0).
  task automatic start_cmd(input logic f, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] n, input logic [7:0] v);
    Start = 1'b1; Fill = f; SrcAddr = s; DstAddr = d; Len = n; FillValue = v;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Step cycles until Done is seen; cyc = cycle index after Start, -1 on timeout.
  task automatic wait_done(input int max, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max; k++) begin
      if (Done) begin cyc = k; break; end
      @(negedge CLK);
    end
    if (cyc >= 0) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; Start = 1'b0; Fill = 1'b0; SrcAddr = '0; DstAddr = '0;
    Len = '0; FillValue = '0; BusGrant = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_dat = '0;
    repeat (3) @(negedge CLK);
    checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL reset_busreq: got %b want 0", BusReq); end
    checks++; if (MemWE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", MemWE); end
    checks++; if (MemAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", MemAddress); end
    checks++; if (MemWData !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", MemWData); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_copy();
    int w0, dc;
    logic b_at_done, r_at_done;
    poke(16'h0037, 8'hDD); poke(16'h0038, 8'h00); poke(16'h0039, 8'h11);
    w0 = we_total; dc = -1; b_at_done = 1'b1; r_at_done = 1'b1;
    start_cmd(1'b0, 16'h0037, 16'h0200, 16'd3, 8'h00);
    checks++; if (Busy !== 1'b1 || BusReq !== 1'b1) begin errors++; $display("FAIL copy_req: busy=%b busreq=%b want 1/1", Busy, BusReq); end
    for (int k = 1; k <= 20; k++) begin
      if (Done) begin dc = k; b_at_done = Busy; r_at_done = BusReq; break; end
      @(negedge CLK);
    end
    @(negedge CLK);
    checks++; if (dc != 8) begin errors++; $display("FAIL copy_done_cycle: got %0d want 8", dc); end
    checks++; if (b_at_done !== 1'b0 || r_at_done !== 1'b0) begin errors++; $display("FAIL copy_done_idle: busy=%b busreq=%b want 0/0", b_at_done, r_at_done); end
    checks++; if (we_total - w0 != 3) begin errors++; $display("FAIL copy_we_count: got %0d want 3", we_total - w0); end
    checks++; if (mem[16'h0200] !== 8'hDD || mem[16'h0201] !== 8'h00 || mem[16'h0202] !== 8'h11)
      begin errors++; $display("FAIL copy_data: got %h %h %h want dd 00 11", mem[16'h0200], mem[16'h0201], mem[16'h0202]); end
  endtask

  task automatic test_fill();
    int first, last, n, dc;
    poke(16'h00FF, 8'h12); poke(16'h0104, 8'h34);
    first = -1; last = -1; n = 0; dc = -1;
    start_cmd(1'b1, 16'h0000, 16'h0100, 16'd4, 8'hEA);
    for (int k = 1; k <= 20; k++) begin
      if (MemWE) begin if (first < 0) first = k; last = k; n++; end
      if (Done) begin dc = k; break; end
      @(negedge CLK);
    end
    @(negedge CLK);
    checks++; if (n != 4) begin errors++; $display("FAIL fill_we_count: got %0d want 4", n); end
    checks++; if (last - first + 1 != 4) begin errors++; $display("FAIL fill_we_consecutive: span %0d want 4", last - first + 1); end
    checks++; if (dc != 6 || dc != last + 1) begin errors++; $display("FAIL fill_done_cycle: got %0d want 6 (last WE %0d)", dc, last); end
    for (int a = 0; a < 4; a++) begin
      checks++; if (mem[16'h0100 + a] !== 8'hEA) begin errors++; $display("FAIL fill_data[%0d]: got %h want ea", a, mem[16'h0100 + a]); end
    end
    checks++; if (mem[16'h00FF] !== 8'h12 || mem[16'h0104] !== 8'h34)
      begin errors++; $display("FAIL fill_bounds: got %h %h want 12 34", mem[16'h00FF], mem[16'h0104]); end
  endtask

  task automatic test_len0();
    int dc;
    logic seen;
    dc = -1; seen = 1'b0;
    start_cmd(1'b0, 16'h1234, 16'h4321, 16'd0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      if (Done && dc < 0) dc = k;
      if (BusReq || Busy || MemWE) seen = 1'b1;
      @(negedge CLK);
    end
    checks++; if (dc != 1) begin errors++; $display("FAIL len0_done_cycle: got %0d want 1", dc); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL len0_bus_activity: got %b want 0", seen); end
  endtask

  task automatic test_grant_loss();
    int w0, dc;
    logic we_low;
    poke(16'h0400, 8'h11); poke(16'h0401, 8'h22);
    w0 = we_total; we_low = 1'b0;
    start_cmd(1'b0, 16'h0400, 16'h0500, 16'd2, 8'h00);
    for (int k = 0; k < 10 && !MemWE; k++) @(negedge CLK);
    checks++; if (MemWE !== 1'b1 || MemAddress !== 16'h0500) begin errors++; $display("FAIL gl_first_write: we=%b addr=%h want 1/0500", MemWE, MemAddress); end
    // Drop grant during the first WRITE; CPU clobbers the source byte.
    BusGrant = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_dat = 8'h55;
    #1;
    if (MemWE) we_low = 1'b1;
    @(negedge CLK);
    cpu_we = 1'b0;
    if (MemWE) we_low = 1'b1;
    @(negedge CLK);
    if (MemWE) we_low = 1'b1;
    checks++; if (BusReq !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL gl_hold_req: busreq=%b busy=%b want 1/1", BusReq, Busy); end
    @(negedge CLK);
    BusGrant = 1'b1;
    @(negedge CLK);
    checks++; if (we_low !== 1'b0) begin errors++; $display("FAIL gl_we_while_low: got %b want 0", we_low); end
    checks++; if (MemAddress !== 16'h0400 || MemWE !== 1'b0) begin errors++; $display("FAIL gl_reread: addr=%h we=%b want 0400/0", MemAddress, MemWE); end
    wait_done(20, dc);
    checks++; if (dc < 0) begin errors++; $display("FAIL gl_done_timeout: got %0d want >=0", dc); end
    checks++; if (mem[16'h0500] !== 8'h55 || mem[16'h0501] !== 8'h22)
      begin errors++; $display("FAIL gl_data: got %h %h want 55 22", mem[16'h0500], mem[16'h0501]); end
    checks++; if (we_total - w0 != 2 || we_nogrant != 0)
      begin errors++; $display("FAIL gl_we_count: got %0d (nogrant %0d) want 2 (0)", we_total - w0, we_nogrant); end
  endtask

  task automatic test_wrap();
    int dc;
    poke(16'hFFFF, 8'hAB); poke(16'h0000, 8'hCD);
    start_cmd(1'b0, 16'hFFFF, 16'h01FF, 16'd2, 8'h00);
    wait_done(20, dc);
    checks++; if (dc != 6) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 6", dc); end
    checks++; if (mem[16'h01FF] !== 8'hAB || mem[16'h0200] !== 8'hCD)
      begin errors++; $display("FAIL wrap_data: got %h %h want ab cd", mem[16'h01FF], mem[16'h0200]); end
    checks++; if (MemAddress !== 16'h0200 || MemWData !== 8'hCD)
      begin errors++; $display("FAIL wrap_hold: addr=%h wdata=%h want 0200/cd", MemAddress, MemWData); end
  endtask

  task automatic test_reset_mid_fill();
    int w0, d0, dc;
    poke(16'h0302, 8'h99);
    w0 = we_total; d0 = done_total;
    start_cmd(1'b1, 16'h0000, 16'h0300, 16'd5, 8'h77);
    for (int k = 0; k < 10 && (we_total - w0) < 2; k++) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    checks++; if (MemWE !== 1'b0 || Busy !== 1'b0 || BusReq !== 1'b0)
      begin errors++; $display("FAIL rst_abort: we=%b busy=%b busreq=%b want 0/0/0", MemWE, Busy, BusReq); end
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK);
    checks++; if (done_total != d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_total - d0); end
    checks++; if (we_total - w0 != 2) begin errors++; $display("FAIL rst_we_count: got %0d want 2", we_total - w0); end
    checks++; if (mem[16'h0300] !== 8'h77 || mem[16'h0301] !== 8'h77 || mem[16'h0302] !== 8'h99)
      begin errors++; $display("FAIL rst_data: got %h %h %h want 77 77 99", mem[16'h0300], mem[16'h0301], mem[16'h0302]); end
    start_cmd(1'b1, 16'h0000, 16'h0310, 16'd1, 8'h5A);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rst_restart_busy: got %b want 1", Busy); end
    wait_done(20, dc);
    checks++; if (dc != 3 || mem[16'h0310] !== 8'h5A)
      begin errors++; $display("FAIL rst_restart: done cycle %0d data %h want 3/5a", dc, mem[16'h0310]); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_len0();
    test_grant_loss();
    test_wrap();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Bus-initiator block on the 6502 memory port: performs block copy or block fill by driving WE/Address/DataIn and sampling DataOut of the synchronous RAM.
- The RAM has 1-cycle registered read latency and is write-exclusive per cycle.
- Arbitrates against the CPU with a BusReq/BusGrant handshake; the CPU stalls (RDY low) while grant is high.
- Used for zero-page/stack init, screen fills and test-program relocation.

Parameters:
- ADDR_W, 16, memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  synchronous active-low reset.
- Start  in  1  one-cycle command strobe; sampled only in IDLE.
- Fill  in  1  1 = fill with FillValue, 0 = copy from SrcAddr; latched on Start.
- SrcAddr  in  ADDR_W  copy source base; latched on Start.
- DstAddr  in  ADDR_W  destination base; latched on Start.
- Len  in  ADDR_W  byte count; 0 = no-op; latched on Start.
- FillValue  in  DATA_W  fill byte; latched on Start.
- BusGrant  in  1  arbiter grant; memory may be driven only while high.
- MemRData  in  DATA_W  memory DataOut.
- BusReq  out  1  bus request to arbiter.
- MemWE  out  1  memory WE.
- MemAddress  out  ADDR_W  memory Address.
- MemWData  out  DATA_W  memory DataIn.
- Busy  out  1  high from cycle after accepted Start until Done.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, checked every cycle and dominant over all other inputs: state=IDLE; BusReq=0, MemWE=0, MemAddress=0, MemWData=0, Busy=0, Done=0. Counters are cleared. A reset mid-transfer aborts the transfer with no further writes and no Done pulse.
- IDLE:
  - Start=1 with Len!=0: latch all command inputs, remaining=Len, go to REQ.
  - Start=1 with Len==0: pulse Done next cycle; no BusReq, no Busy.
- REQ: BusReq=1, Busy=1. When BusGrant is sampled high, go to READ if Fill=0, else WRITE.
- READ: MemAddress=src, MemWE=0; next state WRITE. The memory registers src data at this edge, so MemRData is valid during WRITE.
- WRITE: MemAddress=dst, MemWE=1, MemWData = Fill ? FillValue : MemRData. At the edge: dst++, src++ (copy), remaining--. Next state:
  - DONE if remaining becomes 0.
  - Otherwise READ (copy) or WRITE (fill).
- Grant loss:
  - BusGrant is sampled each cycle in READ/WRITE. If low, MemWE is forced to 0 and the state becomes REQ. Addresses and remaining are not advanced.
  - A copy paused in WRITE resumes at READ of the same src, because the CPU may have clobbered DataOut. A fill resumes at WRITE.
- DONE: BusReq=0, Busy=0, Done=1 for exactly one cycle, then IDLE.
- BusReq stays high continuously from REQ through the last WRITE. It deasserts in the DONE cycle.
- Throughput with grant held: copy = 2 cycles/byte, fill = 1 cycle/byte. Start→Done latency for copy is 2 + 2·Len cycles when grant is already high.
- Copy order is ascending. Overlap with dst>src is not corrected; this is documented software responsibility.
- src/dst wrap $FFFF→$0000.
- Start while Busy is ignored.
- MemAddress and MemWData hold their last value in IDLE/DONE; MemWE=0 outside WRITE.

Decomposition:
- Shared package mem_bus_pkg: state enum (IDLE, REQ, READ, WRITE, DONE), ADDR_W/DATA_W defaults, and the address-increment wrap helper.
- A single flat module; no sub-module is needed. The command latch and counters are local registers.

Test Plan:
- Copy, Len=3, Src=$0037, Dst=$0200, grant tied high; mem[$37..$39]=dd,00,11 → mem[$0200..$0202]=dd,00,11; Done pulses at cycle 8 after Start; exactly 3 WE cycles.
- Fill=1, Len=4, Dst=$0100, FillValue=$EA → $0100–$0103=$EA; 4 consecutive WE cycles; Done one cycle later; $00FF and $0104 untouched.
- Len=0 → Done one cycle after Start; BusReq, Busy and MemWE never assert.
- Copy Len=2; drop BusGrant for 3 cycles during the first WRITE and have the bench write $55 to the src address meanwhile → no WE while grant low; same src re-read after regrant; dst receives $55.
- Wrap: copy Len=2, Src=$FFFF, Dst=$01FF; mem[$FFFF]=$AB, mem[$0000]=$CD → mem[$01FF]=$AB, mem[$0200]=$CD.
- RESET_N low for 1 cycle mid-fill (after 2 of 5 bytes) → MemWE=0 and Busy=0 next cycle; no Done; only 2 bytes written; a new Start is accepted afterwards.
